// File: rtl/ser_stream.sv
// ser_stream: FIFO-buffered parallel-to-serial converter with per-word length,
// selectable bit order and downstream back-pressure on the serial side.
module ser_stream #(
    parameter int WIDTH   = 16,
    parameter int LEN_W   = $clog2(WIDTH) + 1,
    parameter int DEPTH   = 4,
    parameter int MIN_LEN = 3
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic             data_val_i,
    output logic             data_rdy_o,
    input  logic [WIDTH-1:0] data_i,
    input  logic [LEN_W-1:0] data_mod_i,
    input  logic             msb_first_i,
    output logic             ser_data_o,
    output logic             ser_data_val_o,
    output logic             ser_last_o,
    input  logic             ser_rdy_i,
    output logic             drop_o,
    output logic             busy_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = WIDTH + LEN_W + 1;

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    logic [ENT_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    state_t           state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [LEN_W-1:0] bit_cnt_reg;
    logic             msb_reg;
    logic             drop_reg;

    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             too_short;
    logic             push;
    logic             pop;
    logic             bit_done;
    logic [LEN_W-1:0] eff_len;
    logic [WIDTH-1:0] head_data;
    logic [LEN_W-1:0] head_len;
    logic             head_msb;
    logic [WIDTH-1:0] shl_next;
    logic [WIDTH-1:0] shr_next;

    assign fifo_full  = (count_reg == CNT_W'(DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign accept     = data_val_i & ~fifo_full;
    assign too_short  = (data_mod_i != '0) && (data_mod_i < LEN_W'(MIN_LEN));
    assign eff_len    = (data_mod_i == '0 || data_mod_i > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : data_mod_i;
    assign push       = accept & ~too_short;
    assign bit_done   = (state_reg == ST_SHIFT) && ser_rdy_i && (bit_cnt_reg == '0);
    // Pop either to start from idle or to chain the next word without a bubble.
    assign pop        = ~fifo_empty & ((state_reg == ST_IDLE) | bit_done);

    assign {head_data, head_len, head_msb} = fifo_mem[rd_ptr_reg];

    assign shl_next[0]       = 1'b0;
    assign shr_next[WIDTH-1] = 1'b0;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
            assign shl_next[gi]   = shift_reg[gi-1];
            assign shr_next[gi-1] = shift_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {data_i, eff_len, msb_first_i};
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            msb_reg     <= 1'b0;
            drop_reg    <= 1'b0;
        end else begin
            drop_reg <= accept & too_short;
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (push & ~pop)      count_reg <= count_reg + CNT_W'(1);
            else if (pop & ~push) count_reg <= count_reg - CNT_W'(1);

            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        state_reg   <= ST_SHIFT;
                        shift_reg   <= head_data;
                        bit_cnt_reg <= head_len - LEN_W'(1);
                        msb_reg     <= head_msb;
                    end
                end
                ST_SHIFT: begin
                    if (ser_rdy_i) begin
                        if (bit_cnt_reg == '0) begin
                            if (pop) begin
                                shift_reg   <= head_data;
                                bit_cnt_reg <= head_len - LEN_W'(1);
                                msb_reg     <= head_msb;
                            end else begin
                                state_reg <= ST_IDLE;
                            end
                        end else begin
                            shift_reg   <= msb_reg ? shl_next : shr_next;
                            bit_cnt_reg <= bit_cnt_reg - LEN_W'(1);
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign data_rdy_o     = ~fifo_full;
    assign ser_data_val_o = (state_reg == ST_SHIFT);
    assign ser_data_o     = ser_data_val_o & (msb_reg ? shift_reg[WIDTH-1] : shift_reg[0]);
    assign ser_last_o     = ser_data_val_o & (bit_cnt_reg == '0);
    assign drop_o         = drop_reg;
    assign busy_o         = ~fifo_empty | ser_data_val_o;

endmodule

// File: tb/tb_ser_stream.sv
// Directed bench for ser_stream: hand-written serial bit sequences are checked
// bit by bit, including back-pressure, drops and asynchronous reset.
module tb_ser_stream;
    localparam int WIDTH   = 16;
    localparam int LEN_W   = 5;
    localparam int DEPTH   = 4;
    localparam int MIN_LEN = 3;

    logic             clk_i       = 1'b0;
    logic             arst_n_i    = 1'b0;
    logic             data_val_i  = 1'b0;
    logic [WIDTH-1:0] data_i      = '0;
    logic [LEN_W-1:0] data_mod_i  = '0;
    logic             msb_first_i = 1'b0;
    logic             ser_rdy_i   = 1'b0;
    logic             data_rdy_o;
    logic             ser_data_o;
    logic             ser_data_val_o;
    logic             ser_last_o;
    logic             drop_o;
    logic             busy_o;

    int total = 0;
    int bad   = 0;

    logic [15:0] d5   [5];
    logic        msb5 [5];
    logic [31:0] seq5 [5];

    ser_stream #(
        .WIDTH   (WIDTH),
        .LEN_W   (LEN_W),
        .DEPTH   (DEPTH),
        .MIN_LEN (MIN_LEN)
    ) dut (
        .clk_i          (clk_i),
        .arst_n_i       (arst_n_i),
        .data_val_i     (data_val_i),
        .data_rdy_o     (data_rdy_o),
        .data_i         (data_i),
        .data_mod_i     (data_mod_i),
        .msb_first_i    (msb_first_i),
        .ser_data_o     (ser_data_o),
        .ser_data_val_o (ser_data_val_o),
        .ser_last_o     (ser_last_o),
        .ser_rdy_i      (ser_rdy_i),
        .drop_o         (drop_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " val"},  32'(ser_data_val_o), 32'd0);
        chk({tag, " busy"}, 32'(busy_o),         32'd0);
        chk({tag, " rdy"},  32'(data_rdy_o),     32'd1);
    endtask

    task automatic offer(input logic [15:0] d, input logic [4:0] m, input logic msb);
        data_val_i  = 1'b1;
        data_i      = d;
        data_mod_i  = m;
        msb_first_i = msb;
    endtask

    task automatic send(input logic [15:0] d, input logic [4:0] m, input logic msb);
        offer(d, m, msb);
        tick();
        data_val_i = 1'b0;
    endtask

    // seq holds the expected bits with the first transmitted bit at position len-1.
    task automatic stream(input string tag, input logic [31:0] seq, input int len);
        for (int k = 0; k < len; k++) begin
            chk({tag, " val"},  32'(ser_data_val_o), 32'd1);
            chk({tag, " bit"},  32'(ser_data_o),     32'(seq[len-1-k]));
            chk({tag, " last"}, 32'(ser_last_o),     32'(k == len - 1));
            tick();
        end
        $display("word %s: %0d bits checked", tag, len);
    endtask

    task automatic chk_frozen(input string tag);
        chk({tag, " val"},  32'(ser_data_val_o), 32'd1);
        chk({tag, " bit"},  32'(ser_data_o),     32'd1);
        chk({tag, " last"}, 32'(ser_last_o),     32'd0);
    endtask

    initial begin
        ser_rdy_i = 1'b1;
        #3;
        chk("reset bit",  32'(ser_data_o),     32'd0);
        chk("reset last", 32'(ser_last_o),     32'd0);
        chk("reset drop", 32'(drop_o),         32'd0);
        chk_idle("reset");
        tick();
        #2 arst_n_i = 1'b1;
        tick();

        // MSB-first, 8 bits
        send(16'hA5C3, 5'd8, 1'b1);
        chk("t1 latency val",  32'(ser_data_val_o), 32'd0);
        chk("t1 latency busy", 32'(busy_o),         32'd1);
        tick();
        stream("t1", 32'b10100101, 8);
        chk_idle("t1 end");

        // LSB-first, full width via mod=0
        send(16'hA5C3, 5'd0, 1'b0);
        tick();
        stream("t2", 32'b1100001110100101, 16);
        chk_idle("t2 end");

        // Oversized length saturates to full width
        send(16'hA5C3, 5'd31, 1'b1);
        tick();
        stream("sat", 32'hA5C3, 16);
        chk_idle("sat end");

        // Back-to-back 3-bit MSB and 4-bit LSB words, no bubble
        offer(16'hE000, 5'd3, 1'b1);
        tick();
        chk("t3 first val", 32'(ser_data_val_o), 32'd0);
        offer(16'h000F, 5'd4, 1'b0);
        tick();
        data_val_i = 1'b0;
        stream("t3a", 32'b111, 3);
        stream("t3b", 32'b1111, 4);
        chk_idle("t3 end");

        // Illegal short lengths are consumed and dropped
        offer(16'h1234, 5'd2, 1'b1);
        tick();
        chk("t4 drop1", 32'(drop_o), 32'd1);
        chk_idle("t4 a");
        offer(16'h5678, 5'd1, 1'b0);
        tick();
        chk("t4 drop2", 32'(drop_o), 32'd1);
        chk_idle("t4 b");
        data_val_i = 1'b0;
        tick();
        chk("t4 drop clear", 32'(drop_o), 32'd0);
        chk_idle("t4 c");

        // Back-pressure: fill FIFO behind a stalled shifter
        d5[0] = 16'h9000; msb5[0] = 1'b1; seq5[0] = 32'b1001;
        d5[1] = 16'h6000; msb5[1] = 1'b1; seq5[1] = 32'b0110;
        d5[2] = 16'hB000; msb5[2] = 1'b1; seq5[2] = 32'b1011;
        d5[3] = 16'h0004; msb5[3] = 1'b0; seq5[3] = 32'b0010;
        d5[4] = 16'hD000; msb5[4] = 1'b1; seq5[4] = 32'b1101;
        ser_rdy_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t5 rdy before push", 32'(data_rdy_o), 32'd1);
            offer(d5[i], 5'd4, msb5[i]);
            tick();
            if (i >= 1) chk_frozen("t5 stall");
        end
        chk("t5 full rdy", 32'(data_rdy_o), 32'd0);
        offer(16'hF000, 5'd4, 1'b1);
        tick();
        chk("t5 still full", 32'(data_rdy_o), 32'd0);
        chk_frozen("t5 stall rejected");
        data_val_i = 1'b0;
        tick();
        chk_frozen("t5 stall hold");
        ser_rdy_i = 1'b1;
        stream("t5w0", seq5[0], 4);
        chk("t5 rdy after pop", 32'(data_rdy_o), 32'd1);
        for (int i = 1; i < 5; i++) begin
            stream("t5wn", seq5[i], 4);
        end
        chk_idle("t5 end");

        // Asynchronous reset mid-word with two words queued
        offer(16'hA5C3, 5'd8, 1'b1);
        tick();
        offer(16'h9000, 5'd4, 1'b1);
        tick();
        offer(16'h6000, 5'd4, 1'b1);
        tick();
        data_val_i = 1'b0;
        chk("t6 pre val",  32'(ser_data_val_o), 32'd1);
        chk("t6 pre bit",  32'(ser_data_o),     32'd0);
        chk("t6 pre busy", 32'(busy_o),         32'd1);
        #2 arst_n_i = 1'b0;
        #1;
        chk("t6 rst bit",  32'(ser_data_o), 32'd0);
        chk("t6 rst last", 32'(ser_last_o), 32'd0);
        chk("t6 rst drop", 32'(drop_o),     32'd0);
        chk_idle("t6 rst");
        offer(16'hFFFF, 5'd4, 1'b1);
        tick();
        chk_idle("t6 rst held");
        #3;
        data_val_i = 1'b0;
        arst_n_i   = 1'b1;
        tick();
        chk_idle("t6 released");
        send(16'h000F, 5'd5, 1'b0);
        tick();
        stream("t6", 32'b11110, 5);
        chk_idle("t6 end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ser_stream.md
# ser_stream

Parametrised multi-word serializer with an input FIFO, variable word length, selectable bit order and downstream back-pressure. Words arrive on a parallel valid/ready port, are queued, then shifted out one bit per accepted cycle with valid and last markers. It replaces the single-word, busy-gated serializer wherever the link must absorb bursts or tolerate a stalling consumer.

## Interface
- WIDTH, 16: parallel word width in bits, ≥ 4.
- LEN_W, $clog2(WIDTH)+1: width of data_mod_i.
- DEPTH, 4: FIFO depth in words, power of 2, ≥ 2.
- MIN_LEN, 3: minimum legal word length. Shorter non-zero lengths are dropped.
- clk_i  in  1  clock; all logic on the rising edge.
- arst_n_i  in  1  reset, asynchronous, active-low.
- data_val_i  in  1  input word valid.
- data_rdy_o  out  1  FIFO can accept a word; equals !full.
- data_i  in  WIDTH  parallel word.
- data_mod_i  in  LEN_W  bits to send. 0 means WIDTH. Values above WIDTH saturate to WIDTH.
- msb_first_i  in  1  bit order for this word; 1 = MSB first. Latched per word.
- ser_data_o  out  1  serial bit.
- ser_data_val_o  out  1  ser_data_o is valid.
- ser_last_o  out  1  current bit is the last bit of its word.
- ser_rdy_i  in  1  consumer accepts the current bit.
- drop_o  out  1  one-cycle pulse: a word was accepted with illegal length and discarded.
- busy_o  out  1  FIFO non-empty or shifter active.

## Operation
- Input handshake: a word is accepted on an edge where data_val_i & data_rdy_o.
- Legal words:
  - Effective length L = (data_mod_i == 0 || data_mod_i > WIDTH) ? WIDTH : data_mod_i.
  - If L ≥ MIN_LEN, {data_i, L, msb_first_i} is pushed to the FIFO.
- Illegal words:
  - If 0 < data_mod_i < MIN_LEN, the word is consumed but not stored.
  - drop_o is high for the cycle after acceptance.
- data_rdy_o depends only on FIFO occupancy. There is no combinational path from ser_rdy_i; a pop in the same cycle does not raise data_rdy_o when full.
- Shifter states:
  - IDLE: ser_data_val_o = 0. If the FIFO is non-empty, pop the head, load shift register and down-counter (= L−1), go to SHIFT.
  - SHIFT: ser_data_val_o = 1. The bit advances only on edges with ser_rdy_i = 1. When ser_rdy_i = 0, ser_data_o, ser_data_val_o and ser_last_o hold.
  - SHIFT with last bit accepted (counter 0 & ser_rdy_i): if the FIFO is non-empty, pop and load the next word on the same edge (stay in SHIFT, no bubble); otherwise go to IDLE.
- Bit order:
  - MSB-first sends data[WIDTH-1] down to data[WIDTH-L] (top L bits).
  - LSB-first sends data[0] up to data[L-1] (bottom L bits).
- ser_last_o = ser_data_val_o & (counter == 0).
- busy_o = (FIFO count != 0) | (state == SHIFT).
- Internal counters:
  - FIFO pointers are $clog2(DEPTH) bits, wrapping naturally.
  - Occupancy is $clog2(DEPTH)+1 bits.
  - Push and pop in the same edge leave occupancy unchanged.

## Timing
- Reset (arst_n_i low) takes effect immediately, independent of clk_i.
  - FIFO is emptied and the shifter goes to IDLE.
  - ser_data_o = 0, ser_data_val_o = 0, ser_last_o = 0, drop_o = 0, busy_o = 0, data_rdy_o = 1.
- Reset mid-word truncates the word; it is never resumed.
- Inputs are ignored while reset is asserted.
- Latency: a word accepted at edge N into an empty, idle block has its first bit valid after edge N+1.
- A word of length L with ser_rdy_i held high occupies exactly L cycles of ser_data_val_o.
- Back-to-back queued words are streamed with zero idle cycles between them.
- drop_o is asserted after edge N for exactly one cycle and does not affect FIFO state.
- With DEPTH words queued and the shifter busy, data_rdy_o is 0 until the edge after the first pop.

## Test plan
- Reset, then accept data_i=16'hA5C3, mod=8, MSB-first, ser_rdy_i=1 -> bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting the cycle after edge N+1; ser_last_o only on the 8th; then busy_o=0.
- Same word, mod=0, LSB-first -> 16 bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; ser_last_o on the 16th.
- Push mod=3 then mod=4 back-to-back (data 16'hE000, 16'h000F, MSB then LSB) -> 7 contiguous valid cycles 1,1,1,1,1,1,1; ser_last_o on cycles 3 and 7.
- mod=2 and mod=1 words -> drop_o pulses twice, no ser_data_val_o, FIFO empty, busy_o stays 0.
- ser_rdy_i=0 while 5 words are pushed (DEPTH=4) -> 4 accepted plus 1 in the shifter; data_rdy_o=0 and ser outputs frozen. Release ser_rdy_i -> all words emerge in order, none lost or duplicated.
- arst_n_i pulsed low mid-word with 2 words queued -> all outputs 0 immediately, data_rdy_o=1; the next accepted word serializes normally from its first bit.
